// File: rtl/tx_scheduler.sv
// tx_scheduler: round-robin arbiter that shares one serial shift transmitter
// between NUM_REQ requesters. It latches the winner's word, re-arms the
// transmitter, paces it with shift_tick and acknowledges on completion.
// Optional feature macro: TX_WATCHDOG_EN adds a SHIFT-state timeout that
// aborts a stuck transfer and pulses error.
module tx_scheduler #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned GAP     = 2,
  parameter int unsigned TIMEOUT = 40
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*WIDTH-1:0]   word_in,
  input  logic                       shift_tick,
  output logic [NUM_REQ-1:0]         ack,
  output logic                       busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       tx_reset,
  output logic                       tx_enable,
  output logic [WIDTH-1:0]           tx_word,
  input  logic                       tx_out,
  input  logic                       tx_done,
  output logic                       serial_out,
  output logic                       serial_valid,
  output logic                       error
);

  localparam int unsigned IDW  = $clog2(NUM_REQ);
  localparam int unsigned CNTW = $clog2(WIDTH + 2);
  localparam int unsigned GAPW = 4;
  localparam int unsigned WDW  = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARM,
    S_SHIFT,
    S_ACK
  } state_t;

  state_t             state;
  logic [CNTW-1:0]    bit_cnt;
  logic [GAPW-1:0]    gap_cnt;
  logic [IDW-1:0]     rr_ptr;
  logic [IDW-1:0]     next_ptr;
  logic               pick_valid;
  logic [IDW-1:0]     pick_id;
  int unsigned        cand;

  // Transmitter is enabled only in SHIFT and only on pacing ticks
  assign tx_enable  = (state == S_SHIFT) && shift_tick;
  assign serial_out = tx_out;
  assign next_ptr   = (grant_id == IDW'(NUM_REQ - 1)) ? '0 : grant_id + IDW'(1);

  // Round-robin pick: first asserted request at or after rr_ptr, wrapping
  always_comb begin
    pick_valid = 1'b0;
    pick_id    = '0;
    cand       = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = 32'(rr_ptr) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!pick_valid && req[IDW'(cand)]) begin
        pick_valid = 1'b1;
        pick_id    = IDW'(cand);
      end
    end
  end

`ifdef TX_WATCHDOG_EN
  logic [WDW-1:0] wd_cnt;
  logic           error_q;
  assign error = error_q;
`else
  logic [WDW-1:0] unused_timeout;
  assign unused_timeout = WDW'(TIMEOUT);
  assign error          = 1'b0;
`endif

  // Scheduler FSM with registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      ack          <= '0;
      busy         <= 1'b0;
      grant_id     <= '0;
      tx_reset     <= 1'b1;
      tx_word      <= '0;
      serial_valid <= 1'b0;
      bit_cnt      <= '0;
      gap_cnt      <= '0;
      rr_ptr       <= '0;
`ifdef TX_WATCHDOG_EN
      wd_cnt       <= '0;
      error_q      <= 1'b0;
`endif
    end else begin
      ack          <= '0;
      serial_valid <= 1'b0;
`ifdef TX_WATCHDOG_EN
      error_q      <= 1'b0;
`endif
      case (state)
        S_IDLE: begin
          tx_reset <= 1'b0;
          if (gap_cnt != '0) begin
            gap_cnt <= gap_cnt - GAPW'(1);
          end else if (pick_valid) begin
            grant_id <= pick_id;
            tx_word  <= word_in[32'(pick_id)*WIDTH +: WIDTH];
            tx_reset <= 1'b1;
            busy     <= 1'b1;
            state    <= S_ARM;
          end
        end
        S_ARM: begin
          tx_reset <= 1'b0;
          bit_cnt  <= '0;
`ifdef TX_WATCHDOG_EN
          wd_cnt   <= '0;
`endif
          state    <= S_SHIFT;
        end
        S_SHIFT: begin
          if (tx_enable) begin
            if (bit_cnt != CNTW'(WIDTH + 1)) bit_cnt <= bit_cnt + CNTW'(1);
            serial_valid <= (bit_cnt < CNTW'(WIDTH));
          end
          if (tx_done) begin
            ack   <= NUM_REQ'(1) << grant_id;
            state <= S_ACK;
          end
`ifdef TX_WATCHDOG_EN
          else if (shift_tick) begin
            if (wd_cnt == WDW'(TIMEOUT - 1)) begin
              error_q  <= 1'b1;
              tx_reset <= 1'b1;
              rr_ptr   <= next_ptr;
              gap_cnt  <= GAPW'(GAP);
              busy     <= 1'b0;
              state    <= S_IDLE;
            end else begin
              wd_cnt <= wd_cnt + WDW'(1);
            end
          end
`endif
        end
        S_ACK: begin
          rr_ptr  <= next_ptr;
          gap_cnt <= GAPW'(GAP);
          busy    <= 1'b0;
          state   <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tx_scheduler.sv
// tb_tx_scheduler: randomized bench for tx_scheduler with a behavioural
// transmitter, requester emulation and a transaction-level reference model.
module tb_tx_scheduler;

  localparam int unsigned N       = 4;
  localparam int unsigned W       = 32;
  localparam int unsigned GAP     = 2;
  localparam int unsigned TIMEOUT = 40;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [N-1:0]     req = '0;
  logic [N*W-1:0]   word_in = '0;
  logic             shift_tick = 1'b0;
  logic [N-1:0]     ack;
  logic             busy;
  logic [1:0]       grant_id;
  logic             tx_reset;
  logic             tx_enable;
  logic [W-1:0]     tx_word;
  logic             tx_out;
  logic             tx_done;
  logic             serial_out;
  logic             serial_valid;
  logic             error;

  always #5 clk = ~clk;

  tx_scheduler #(.NUM_REQ(N), .WIDTH(W), .GAP(GAP), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .word_in(word_in),
    .shift_tick(shift_tick), .ack(ack), .busy(busy), .grant_id(grant_id),
    .tx_reset(tx_reset), .tx_enable(tx_enable), .tx_word(tx_word),
    .tx_out(tx_out), .tx_done(tx_done), .serial_out(serial_out),
    .serial_valid(serial_valid), .error(error)
  );

  // Behavioural transmitter: MSB first, done after the (W+1)th enabled cycle
  int unsigned x_cnt = 0;
  logic        x_done = 1'b0;
  logic        x_out = 1'b0;
  logic        inject_done = 1'b0;
  logic        tie_low = 1'b0;

  always @(posedge clk) begin
    if (tx_reset === 1'b1) begin
      x_cnt  <= 0;
      x_done <= 1'b0;
      x_out  <= 1'b0;
    end else begin
      if (inject_done) x_done <= 1'b1;
      if (tx_enable === 1'b1) begin
        if (x_cnt < W) x_out <= tx_word[W-1-x_cnt];
        else           x_done <= 1'b1;
        if (x_cnt <= W) x_cnt <= x_cnt + 1;
      end
    end
  end
  assign tx_out  = x_out;
  assign tx_done = x_done & ~tie_low;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: transaction-level arbitration and payload scoreboard
  logic [N-1:0]   prev_req = '0;
  logic [N*W-1:0] prev_words = '0;
  int             m_ptr = 0;
  bit             in_xfer = 0;
  int             exp_id = 0;
  int             e_id;
  logic [W-1:0]   exp_word = '0;
  logic [W-1:0]   shreg = '0;
  logic [W-1:0]   last_word = '0;
  int             nbits = 0, shift_cycles = 0, en_cnt = 0, idle_cycles = 0;
  bit             stalled = 0, pend = 0;
  int             done_cnt = 0, abort_cnt = 0;
  int             done_ids[$];
  int             abort_ids[$];

  always @(negedge clk) begin
    if (!rst_n) begin
      in_xfer     = 0;
      nbits       = 0;
      m_ptr       = 0;
      idle_cycles = GAP + 1;
      pend        = 0;
    end else begin
      if (error === 1'b1) begin
        check("err_in_xfer", 64'(in_xfer), 1);
        check("err_ticks", 64'(en_cnt), TIMEOUT);
        check("err_no_ack", 64'(ack), 0);
        abort_ids.push_back(exp_id);
        abort_cnt++;
        m_ptr       = (exp_id + 1) % N;
        in_xfer     = 0;
        idle_cycles = 0;
        pend        = 1;
      end
      if (ack !== '0) begin
        check("ack_in_xfer", 64'(in_xfer), 1);
        check("ack_onehot", 64'(ack), 64'(1) << exp_id);
        check("bit_count", 64'(nbits), W);
        check("word", 64'(shreg), 64'(exp_word));
        check("no_error", 64'(error), 0);
        if (!stalled) check("arm_to_ack", 64'(shift_cycles), W + 2);
        done_ids.push_back(exp_id);
        last_word   = shreg;
        done_cnt++;
        m_ptr       = (exp_id + 1) % N;
        in_xfer     = 0;
        idle_cycles = 0;
        pend        = 1;
      end else if (busy === 1'b1 && tx_reset === 1'b1) begin
        e_id = -1;
        for (int k = 0; k < N; k++)
          if (e_id < 0 && prev_req[(m_ptr + k) % N]) e_id = (m_ptr + k) % N;
        check("grant_id", 64'(grant_id), 64'(e_id));
        if (e_id < 0) e_id = 0;
        exp_id   = e_id;
        exp_word = prev_words[e_id*W +: W];
        check("tx_word", 64'(tx_word), 64'(exp_word));
        if (pend) check("gap_idle", 64'(idle_cycles), GAP + 1);
        else      check("gap_min", 64'(idle_cycles >= GAP + 1), 1);
        in_xfer      = 1;
        nbits        = 0;
        shreg        = '0;
        shift_cycles = 0;
        en_cnt       = 0;
        stalled      = 0;
      end else if (in_xfer) begin
        shift_cycles++;
        if (!shift_tick) stalled = 1;
        if (tx_enable === 1'b1) en_cnt++;
        if (serial_valid === 1'b1) begin
          shreg = {shreg[W-2:0], serial_out};
          nbits++;
        end
      end
      if (busy === 1'b0) begin
        idle_cycles++;
        if (req == '0) pend = 0;
      end
      prev_req   = req;
      prev_words = word_in;
    end
  end

  // Stimulus: requesters, pacing and scenario sequencing
  int cyc = 0;
  int tick_mode = 0;
  bit rearm = 0;
  bit rand_req = 0;
  int base;
  int n;

  task automatic step();
    @(posedge clk);
    #2;
    cyc++;
    for (int i = 0; i < N; i++) begin
      if (ack[i] === 1'b1) begin
        if (rearm) word_in[i*W +: W] = $urandom;
        else       req[i] = 1'b0;
      end
    end
    if (rand_req)
      for (int i = 0; i < N; i++)
        if (!req[i] && $urandom_range(7) == 0) begin
          req[i] = 1'b1;
          word_in[i*W +: W] = $urandom;
        end
    case (tick_mode)
      0:       shift_tick = 1'b1;
      1:       shift_tick = (cyc % 3 == 0);
      default: shift_tick = 1'($urandom_range(1));
    endcase
  endtask

  task automatic wait_done(input int target, input int budget, input string tag);
    int k;
    k = 0;
    while (done_cnt < target && k < budget) begin
      step();
      k++;
    end
    check(tag, 64'(done_cnt), 64'(target));
  endtask

  task automatic check_reset_vals(input string sfx);
    check({"rst_ack_", sfx}, 64'(ack), 0);
    check({"rst_busy_", sfx}, 64'(busy), 0);
    check({"rst_grant_", sfx}, 64'(grant_id), 0);
    check({"rst_txreset_", sfx}, 64'(tx_reset), 1);
    check({"rst_txen_", sfx}, 64'(tx_enable), 0);
    check({"rst_txword_", sfx}, 64'(tx_word), 0);
    check({"rst_valid_", sfx}, 64'(serial_valid), 0);
    check({"rst_error_", sfx}, 64'(error), 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = '0;
    repeat (3) step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic drain(input string tag);
    int k;
    k = 0;
    while ((req != '0 || busy !== 1'b0) && k < 2000) begin
      step();
      k++;
    end
    check(tag, 64'(busy !== 1'b0 || req != '0), 0);
  endtask

  initial begin
    // Reset values and tx_reset held one cycle past reset
    repeat (3) step();
    check_reset_vals("init");
    rst_n = 1'b1;
    #1 check("tx_reset_hold", 64'(tx_reset), 1);
    step();
    check("tx_reset_low", 64'(tx_reset), 0);
    check("busy_idle", 64'(busy), 0);

    // Single request, full-rate ticks
    word_in[W-1:0] = 32'hA5A5_0F0F;
    req = 4'b0001;
    wait_done(1, 200, "single_done");
    check("single_id", 64'(done_ids[0]), 0);
    check("single_word", 64'(last_word), 64'(32'hA5A5_0F0F));
    drain("single_drain");

    // Round-robin with all requesters held and re-armed on ack
    do_reset();
    rearm = 1;
    for (int i = 0; i < N; i++) word_in[i*W +: W] = 32'h1111_1111 * (i + 1);
    base = done_cnt;
    req = '1;
    wait_done(base + 5, 400, "rr_done");
    for (int k = 0; k < 5; k++) check("rr_order", 64'(done_ids[base + k]), 64'(k % N));
    rearm = 0;
    req = '0;
    drain("rr_drain");

    // Paced shifting, one tick every third cycle
    do_reset();
    tick_mode = 1;
    word_in[W-1:0] = 32'h8000_0001;
    base = done_cnt;
    req = 4'b0001;
    wait_done(base + 1, 600, "pace_done");
    check("pace_first_bit", 64'(last_word[W-1]), 1);
    check("pace_last_bit", 64'(last_word[0]), 1);
    check("pace_word", 64'(last_word), 64'(32'h8000_0001));
    drain("pace_drain");

    // Randomized requests and random pacing
    tick_mode = 2;
    rand_req  = 1;
    base = done_cnt;
    wait_done(base + 12, 3000, "rand_done");
    rand_req = 0;
    drain("rand_drain");
    tick_mode = 0;

    // Reset in the middle of SHIFT abandons the transfer
    base = done_cnt;
    word_in[W-1:0] = $urandom;
    req = 4'b0001;
    n = 0;
    while (!(in_xfer && nbits >= 10) && n < 200) begin
      step();
      n++;
    end
    check("mid_reached", 64'(nbits >= 10), 1);
    rst_n = 1'b0;
    req   = '0;
    step();
    check_reset_vals("mid");
    step();
    rst_n = 1'b1;
    step();
    check("mid_no_ack", 64'(done_cnt), 64'(base));
    word_in[W +: W] = $urandom;
    req = 4'b0010;
    wait_done(base + 1, 200, "mid_after_done");
    check("mid_after_id", 64'(done_ids[base]), 1);
    drain("mid_drain");

    // Stale done in IDLE is ignored and cleared by ARM
    repeat (3) step();
    inject_done = 1'b1;
    step();
    inject_done = 1'b0;
    repeat (2) step();
    check("stale_ignored", 64'(busy), 0);
    base = done_cnt;
    word_in[2*W +: W] = $urandom;
    req = 4'b0100;
    wait_done(base + 1, 200, "stale_done");
    drain("stale_drain");

`ifdef TX_WATCHDOG_EN
    // Watchdog abort with the transmitter never finishing
    do_reset();
    tie_low = 1'b1;
    base = done_cnt;
    base = abort_cnt;
    n = done_cnt;
    word_in[W-1:0] = $urandom;
    word_in[W +: W] = $urandom;
    req = 4'b0011;
    for (int k = 0; k < 300 && abort_cnt < base + 2; k++) step();
    check("wd_aborts", 64'(abort_cnt), 64'(base + 2));
    check("wd_first", 64'(abort_ids[base]), 0);
    check("wd_second", 64'(abort_ids[base + 1]), 1);
    check("wd_no_ack", 64'(done_cnt), 64'(n));
    req = '0;
    step();
    tie_low = 1'b0;
    drain("wd_drain");
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/tx_scheduler.md
Name: tx_scheduler

Overview:
- Shares one 32-bit serial shift transmitter between NUM_REQ requesters, e.g. IDCODE, status and user data registers behind the JTAG TAP.
- Arbitrates round-robin, latches the winner's word, re-arms the transmitter and paces its shift enable with shift_tick.
- Counts bits, detects the transmitter's done, acknowledges the requester and then returns the transmitter to idle.
- Sits between the TAP data-register logic and the transmitter instance.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- WIDTH, 32, bits per word; must match the transmitter's buffer width.
- GAP, 2, idle clk cycles forced between two transfers (0..15).
- TIMEOUT, 40, shift_tick-qualified cycles allowed in SHIFT before abort (only used with TX_WATCHDOG_EN).

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst_n  in  1  synchronous active-low reset.
- req  in  NUM_REQ  level request per requester; held until its ack.
- word_in  in  NUM_REQ*WIDTH  requester i's word at bits [i*WIDTH +: WIDTH]; sampled only at grant.
- shift_tick  in  1  pacing strobe; one bit may be shifted per clk where it is high.
- ack  out  NUM_REQ  one-cycle pulse to the granted requester on completion.
- busy  out  1  high in every state except IDLE.
- grant_id  out  $clog2(NUM_REQ)  index of the current or last grant.
- tx_reset  out  1  active-high re-arm to the transmitter.
- tx_enable  out  1  transmitter enable.
- tx_word  out  WIDTH  latched word presented to the transmitter.
- tx_out  in  1  transmitter serial bit.
- tx_done  in  1  transmitter done flag; sticky until tx_reset.
- serial_out  out  1  tx_out passthrough.
- serial_valid  out  1  high while serial_out carries a payload bit.
- error  out  1  one-cycle abort pulse; constant 0 without TX_WATCHDOG_EN.

Behaviour:
- Reset (rst_n=0 at posedge): state=IDLE, ack=0, busy=0, grant_id=0, tx_reset=1, tx_enable=0, tx_word=0, serial_valid=0, error=0, bit_cnt=0, gap_cnt=0, rr_ptr=0.
- Reset mid-transfer abandons the transfer with no ack. tx_reset stays 1 through reset and one cycle after.
- IDLE: tx_reset=0. If any req bit is set and gap_cnt==0, pick the first set req at or after rr_ptr (wrapping). Then:
  - latch grant_id and tx_word <= word_in slice;
  - go to ARM.
- No req: stay in IDLE. gap_cnt decrements to 0 in IDLE.
- ARM (exactly 1 cycle): tx_reset=1, tx_enable=0, bit_cnt<=0. Go to SHIFT.
- SHIFT: tx_reset=0, tx_enable=shift_tick (combinational AND with the SHIFT state).
  - Each cycle with tx_enable=1: bit_cnt increments, saturating at WIDTH+1.
  - serial_valid is registered: (tx_enable && bit_cnt<WIDTH). It aligns with tx_out, which updates on the same edge.
  - Bits emerge MSB first; exactly WIDTH valid bits per transfer.
  - The transmitter raises tx_done after the (WIDTH+1)th enabled cycle. When tx_done=1 is sampled, go to ACK.
- ACK (1 cycle): tx_enable=0 and ack[grant_id]=1. Then:
  - rr_ptr <= grant_id+1, wrapping at NUM_REQ;
  - gap_cnt <= GAP;
  - go to IDLE.
- Requester drops req before ack: the transfer still completes and the ack still pulses; the requester ignores it.
- Requests arriving during a transfer wait. Simultaneous requests are served in round-robin order; no requester waits more than NUM_REQ-1 transfers.
- tx_done seen high in IDLE or ARM is ignored. The ARM-cycle tx_reset clears it.
- shift_tick low for any length of time stalls SHIFT with no state change.

Optional Feature:
- Macro: TX_WATCHDOG_EN.
- With the macro: SHIFT counts shift_tick-qualified cycles.
  - On reaching TIMEOUT without tx_done: pulse error for 1 cycle, no ack, tx_reset=1 for 1 cycle.
  - Then rr_ptr advances past the failed requester, gap_cnt <= GAP, next state IDLE.
- Without the macro: no counter, error tied 0, SHIFT waits indefinitely.

Test Plan:
- Single request: req=4'b0001, word_in[31:0]=32'hA5A5_0F0F, shift_tick=1.
  - serial_out gives 32 valid bits A5A50F0F MSB first.
  - ack[0] pulses once; ARM to ACK spans 34 cycles.
  - busy drops, then 2 gap cycles before the next grant.
- Round-robin: req=4'b1111 held, each re-asserted after its ack, distinct words. Grant order is 0,1,2,3,0; each word serialized intact.
- Pacing: shift_tick high every 3rd cycle, word 32'h8000_0001. Exactly 32 serial_valid cycles, first bit 1 and last bit 1, no extra bits.
- Reset mid-SHIFT: assert rst_n=0 after 10 bits. ack stays 0, outputs take reset values, tx_reset=1. A following request transfers cleanly.
- Stale done: force tx_done=1 in IDLE, then request. ARM clears it and the full 32 bits still shift.
- TX_WATCHDOG_EN: tie tx_done=0, TIMEOUT=40. error pulses after 40 ticks, no ack, next requester granted.
